// File: rtl/clkdiv_prog.sv
// clkdiv_prog: free-running counter plus CH programmable dividers,
// each producing a one-cycle tick and a 50% square wave.
module clkdiv_prog #(
    parameter int WIDTH       = 32,
    parameter int CH          = 2,
    parameter int DIVW        = 16,
    parameter int DEFAULT_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [CH-1:0]      div_load,
    input  logic [DIVW-1:0]    div_val,
    output logic [WIDTH-1:0]   div_res,
    output logic [CH-1:0]      tick,
    output logic [CH-1:0]      sq,
    output logic [CH*DIVW-1:0] div_cur
);

    localparam logic [DIVW-1:0] DEF = DIVW'(DEFAULT_DIV);

    logic [DIVW-1:0] cnt     [CH];
    logic [DIVW-1:0] div_reg [CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            div_res <= '0;
        end else if (en) begin
            div_res <= div_res + 1'b1;
        end
    end

    // Load beats terminal count beats plain counting; en=0 freezes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= '0;
            sq   <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt[i]     <= '0;
                div_reg[i] <= DEF;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                priority case (1'b1)
                    div_load[i]: begin
                        div_reg[i] <= div_val;
                        cnt[i]     <= '0;
                        tick[i]    <= 1'b0;
                    end
                    en && (cnt[i] == div_reg[i]): begin
                        cnt[i]  <= '0;
                        tick[i] <= 1'b1;
                        sq[i]   <= ~sq[i];
                    end
                    en: begin
                        cnt[i]  <= cnt[i] + 1'b1;
                        tick[i] <= 1'b0;
                    end
                    default: begin
                        tick[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_cur
        assign div_cur[g*DIVW +: DIVW] = div_reg[g];
    end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Bench for clkdiv_prog: arithmetic period model compared every cycle,
// plus literal checkpoints from hand-worked sequences.
module tb_clkdiv_prog;

    localparam int WIDTH = 4;
    localparam int CH    = 2;
    localparam int DIVW  = 16;
    localparam int DEF   = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [CH-1:0]      div_load;
    logic [DIVW-1:0]    div_val;
    logic [WIDTH-1:0]   div_res;
    logic [CH-1:0]      tick;
    logic [CH-1:0]      sq;
    logic [CH*DIVW-1:0] div_cur;

    clkdiv_prog #(
        .WIDTH(WIDTH), .CH(CH), .DIVW(DIVW), .DEFAULT_DIV(DEF)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .div_load(div_load), .div_val(div_val),
        .div_res(div_res), .tick(tick), .sq(sq),
        .div_cur(div_cur)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    bit armed      = 0;

    // Model: enabled edges since reset, and per channel enabled edges
    // since last load/reset, the divisor, and sq at the load point.
    longint nres;
    longint n     [CH];
    longint d     [CH];
    bit     base  [CH];
    bit     etick [CH];

    function automatic bit msq(int i);
        return base[i] ^ bit'((n[i] / (d[i] + 1)) & 1);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            nres = 0;
            for (int i = 0; i < CH; i++) begin
                n[i] = 0; d[i] = DEF; base[i] = 0; etick[i] = 0;
            end
        end else begin
            if (en) nres++;
            for (int i = 0; i < CH; i++) begin
                if (div_load[i]) begin
                    base[i]  = msq(i);
                    d[i]     = longint'(div_val);
                    n[i]     = 0;
                    etick[i] = 0;
                end else if (en) begin
                    n[i]++;
                    etick[i] = (n[i] % (d[i] + 1)) == 0;
                end else begin
                    etick[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            logic [CH-1:0]      xt;
            logic [CH-1:0]      xs;
            logic [CH*DIVW-1:0] xc;
            for (int i = 0; i < CH; i++) begin
                xt[i] = etick[i];
                xs[i] = msq(i);
                xc[i*DIVW +: DIVW] = DIVW'(d[i]);
            end
            chk("m_div_res", div_res, nres % (64'd1 << WIDTH));
            chk("m_tick", tick, xt);
            chk("m_sq", sq, xs);
            chk("m_div_cur", div_cur, xc);
        end
    end

    task automatic step(int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        int c0, c1;
        logic [39:0] pat;
        bit s;
        rst = 1; en = 0; div_load = '0; div_val = '0;
        step(3);
        armed = 1;
        chk("rst_div_res", div_res, 0);
        chk("rst_tick", tick, 0);
        chk("rst_sq", sq, 0);
        chk("rst_div_cur", div_cur, 32'h0001_0001);
        rst = 0; en = 1;
        step(2);
        chk("def_tick2", tick, 2'b11);
        chk("def_sq2", sq, 2'b11);
        chk("def_res2", div_res, 2);
        step(6);
        chk("def_res8", div_res, 8);
        chk("def_sq8", sq, 2'b00);
        chk("def_tick8", tick, 2'b11);

        // ch1 divide-by-1 (simultaneous load), then ch0 divide-by-5
        en = 0; div_val = 0; div_load = 2'b11;
        step(1);
        div_val = 4; div_load = 2'b01;
        step(1);
        div_load = 0; en = 1;
        c0 = 0; c1 = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            c0 += int'(tick[0]);
            c1 += int'(tick[1]);
        end
        chk("ratio_ticks0", c0, 4);
        chk("ratio_ticks1", c1, 20);

        // en gating mid-period
        en = 0; div_val = 3; div_load = 2'b01;
        step(1);
        div_load = 0; en = 1;
        step(2);
        en = 0;
        step(5);
        chk("gate_hold_tick", tick[0], 0);
        en = 1;
        step(1);
        chk("gate_ret1", tick[0], 0);
        step(1);
        chk("gate_ret2", tick[0], 1);

        // load on terminal-count cycle suppresses the tick
        step(3);
        s = msq(0);
        div_val = 2; div_load = 2'b01;
        step(1);
        div_load = 0;
        chk("ldpri_tick", tick[0], 0);
        chk("ldpri_sq", sq[0], s);
        chk("ldpri_cur", div_cur[15:0], 2);
        step(2);
        chk("ldpri_t2", tick[0], 0);
        step(1);
        chk("ldpri_t3", tick[0], 1);

        // irregular enable pattern after a shared load
        div_val = 5; div_load = 2'b11;
        step(1);
        div_load = 0;
        chk("shared_cur", div_cur, 32'h0005_0005);
        pat = 40'hF3_A5C9_6E17;
        for (int k = 0; k < 40; k++) begin
            en = pat[k];
            step(1);
        end

        // reset on the edge where a tick is due
        en = 1; div_val = 2; div_load = 2'b11;
        step(1);
        div_load = 0;
        step(2);
        rst = 1;
        step(1);
        chk("mrst_tick", tick, 0);
        chk("mrst_sq", sq, 0);
        chk("mrst_res", div_res, 0);
        chk("mrst_cur", div_cur, 32'h0001_0001);

        // WIDTH=4 wrap
        rst = 0; en = 1;
        step(15);
        chk("wrap_15", div_res, 15);
        step(1);
        chk("wrap_0", div_res, 0);
        step(1);
        chk("wrap_1", div_res, 1);

        // full-scale divisor
        div_val = 16'hFFFF; div_load = 2'b01;
        step(1);
        div_load = 0;
        step(65535);
        chk("max_pre", tick[0], 0);
        step(1);
        chk("max_tick", tick[0], 1);
        step(1);
        chk("max_post", tick[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
